// File: rtl/mipi_bank_router.sv
// ---------------------------------------------------------------------------
// mipi_bank_router
//   Routes one serial MIPI/RFFE engine onto one of NCH SCLK/SDA pad channels.
//   Every pad output is registered (one cycle of latency). The SDA return path
//   from the routed channel passes through a SYNC_STAGES-deep synchroniser.
//   A bank change follows a fixed sequence so the bus is never corrupted:
//   wait for IDLE_CYC consecutive idle engine cycles (DRAIN), drive every
//   line low for GUARD_CYC cycles (PARK), then retarget (SWITCH).
//   The SDA tristate itself lives at the chip top: SDA[i] = sda_oe[i] ? sda_o[i] : Z.
//
// Ports
//   clk          in   1          clock
//   rst_n        in   1          asynchronous active-low reset
//   sel_bank     in   BANK_NBIT  requested channel
//   sclk_in      in   1          serial clock from the engine
//   sdo_in       in   1          serial data from the engine
//   sdo_en_in    in   1          engine drives SDA when 1
//   sdi_out      out  1          synchronised SDA of the routed channel
//   sclk_pad     out  NCH        per-channel SCLK drive
//   sda_o        out  NCH        per-channel SDA output value
//   sda_oe       out  NCH        per-channel SDA output enable
//   sda_i        in   NCH        per-channel SDA pad input
//   cur_bank     out  BANK_NBIT  channel currently routed
//   busy         out  1          bank switch in progress
//   switch_done  out  1          high for the single cycle in which cur_bank updates
//   err_bank     out  1          high the cycle after an out-of-range request is seen
// ---------------------------------------------------------------------------
module mipi_bank_router #(
   parameter int NCH         = 4,
   parameter int BANK_NBIT   = 2,
   parameter int SYNC_STAGES = 2,
   parameter int IDLE_CYC    = 8,
   parameter int GUARD_CYC   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [BANK_NBIT-1:0] sel_bank,
   input  logic                 sclk_in,
   input  logic                 sdo_in,
   input  logic                 sdo_en_in,
   output logic                 sdi_out,
   output logic [NCH-1:0]       sclk_pad,
   output logic [NCH-1:0]       sda_o,
   output logic [NCH-1:0]       sda_oe,
   input  logic [NCH-1:0]       sda_i,
   output logic [BANK_NBIT-1:0] cur_bank,
   output logic                 busy,
   output logic                 switch_done,
   output logic                 err_bank
);

   localparam int IDLE_W  = $clog2(IDLE_CYC + 1);
   localparam int GUARD_W = $clog2(GUARD_CYC + 1);
   localparam logic [BANK_NBIT:0] NCH_L = (BANK_NBIT + 1)'(NCH);

   typedef enum logic [1:0] {ST_ACTIVE, ST_DRAIN, ST_PARK, ST_SWITCH} state_t;

   state_t                r_state, w_state_next;
   logic [BANK_NBIT-1:0]  r_cur, r_target, w_target_next;
   logic [IDLE_W-1:0]     r_idle, w_idle_next;
   logic [GUARD_W-1:0]    r_guard, w_guard_next;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [NCH-1:0]        r_sclk, r_sdo, r_oe;
   logic [NCH-1:0]        w_sclk_next, w_sdo_next, w_oe_next;
   logic                  r_err;
   logic                  w_sel_valid, w_bus_idle, w_route, w_start;
   logic                  w_sda_cur, w_oe_cur;

   assign w_sel_valid = ({1'b0, sel_bank} < NCH_L);
   assign w_bus_idle  = !sclk_in && !sdo_en_in;
   // Pads follow the engine only while a bank is settled or draining.
   assign w_route     = (r_state == ST_ACTIVE) || (r_state == ST_DRAIN);
   assign w_start     = (r_state == ST_ACTIVE) && w_sel_valid && (sel_bank != r_cur);

   // Next-state and Moore outputs
   always_comb begin
      w_state_next  = r_state;
      w_target_next = r_target;
      w_guard_next  = r_guard;
      busy          = (r_state != ST_ACTIVE);
      switch_done   = (r_state == ST_SWITCH);
      case (r_state)
         ST_ACTIVE: begin
            if (w_start) begin
               w_target_next = sel_bank;
               w_state_next  = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Returning to the current bank aborts; abort wins over idle-exit.
            if (sel_bank == r_cur) begin
               w_state_next = ST_ACTIVE;
            end else begin
               if (w_sel_valid) w_target_next = sel_bank;
               if (r_idle == IDLE_W'(IDLE_CYC)) begin
                  w_state_next = ST_PARK;
                  w_guard_next = '0;
               end
            end
         end
         ST_PARK: begin
            if (r_guard == GUARD_W'(GUARD_CYC - 1)) w_state_next = ST_SWITCH;
            else                                    w_guard_next = r_guard + GUARD_W'(1);
         end
         ST_SWITCH: w_state_next = ST_ACTIVE;
         default:   w_state_next = ST_ACTIVE;
      endcase
   end

   // Idle count restarts when a switch is requested so the drain always
   // observes IDLE_CYC fresh idle cycles after the request.
   always_comb begin
      w_idle_next = '0;
      if (!w_start && w_bus_idle)
         w_idle_next = (r_idle == IDLE_W'(IDLE_CYC)) ? r_idle : r_idle + IDLE_W'(1);
   end

   // Per-channel pad drive: routed channel follows the engine, others park low.
   always_comb begin
      w_sclk_next = '0;
      w_sdo_next  = '0;
      w_oe_next   = '1;
      w_sda_cur   = 1'b0;
      w_oe_cur    = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (w_route && (r_cur == BANK_NBIT'(i))) begin
            w_sclk_next[i] = sclk_in;
            w_sdo_next[i]  = sdo_in & sdo_en_in;
            w_oe_next[i]   = sdo_en_in;
         end
         if (r_cur == BANK_NBIT'(i)) begin
            w_sda_cur = sda_i[i];
            w_oe_cur  = r_oe[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_ACTIVE;
         r_cur    <= '0;
         r_target <= '0;
         r_idle   <= '0;
         r_guard  <= '0;
         r_sync   <= '0;
         r_sclk   <= '0;
         r_sdo    <= '0;
         r_oe     <= '1;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_target <= w_target_next;
         r_idle   <= w_idle_next;
         r_guard  <= w_guard_next;
         r_sclk   <= w_sclk_next;
         r_sdo    <= w_sdo_next;
         r_oe     <= w_oe_next;
         r_err    <= (r_state == ST_ACTIVE) && !w_sel_valid;
         if (r_state == ST_SWITCH) begin
            r_cur  <= r_target;
            // Drop history of the old channel so it never reaches the engine.
            r_sync <= '0;
         end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_sda_cur};
         end
      end
   end

   // Engine only sees returned data while the channel is released and settled.
   assign sdi_out  = ((r_state == ST_ACTIVE) && !w_oe_cur) ? r_sync[SYNC_STAGES-1] : 1'b0;
   assign sclk_pad = r_sclk;
   assign sda_o    = r_sdo;
   assign sda_oe   = r_oe;
   assign cur_bank = r_cur;
   assign err_bank = r_err;

endmodule

// File: tb/tb_mipi_bank_router.sv
// ---------------------------------------------------------------------------
// tb_mipi_bank_router
//   Scoreboard bench. The driver applies inputs on the falling edge, advances a
//   behavioural model of the router by one clock and queues the expected
//   outputs; a monitor pops and compares one entry after every rising edge.
//   Directed sequences cover reset mid-park, routing, switch latency, abort,
//   out-of-range requests and SDA readback, followed by random traffic.
// ---------------------------------------------------------------------------
module tb_mipi_bank_router;

   localparam int NCH         = 4;
   localparam int BANK_NBIT   = 3;
   localparam int SYNC_STAGES = 2;
   localparam int IDLE_CYC    = 8;
   localparam int GUARD_CYC   = 4;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [BANK_NBIT-1:0] sel_bank = '0;
   logic                 sclk_in = 1'b0;
   logic                 sdo_in = 1'b0;
   logic                 sdo_en_in = 1'b0;
   logic                 sdi_out;
   logic [NCH-1:0]       sclk_pad, sda_o, sda_oe;
   logic [NCH-1:0]       sda_i = '0;
   logic [BANK_NBIT-1:0] cur_bank;
   logic                 busy, switch_done, err_bank;

   always #5 clk = ~clk;

   mipi_bank_router #(
      .NCH(NCH), .BANK_NBIT(BANK_NBIT), .SYNC_STAGES(SYNC_STAGES),
      .IDLE_CYC(IDLE_CYC), .GUARD_CYC(GUARD_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sel_bank(sel_bank), .sclk_in(sclk_in),
      .sdo_in(sdo_in), .sdo_en_in(sdo_en_in), .sdi_out(sdi_out),
      .sclk_pad(sclk_pad), .sda_o(sda_o), .sda_oe(sda_oe), .sda_i(sda_i),
      .cur_bank(cur_bank), .busy(busy), .switch_done(switch_done),
      .err_bank(err_bank)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phases of a bank change: settled, waiting for idle, parked, retargeting.
   localparam int PH_SETTLED = 0, PH_WAIT_IDLE = 1, PH_PARKED = 2, PH_RETARGET = 3;

   typedef struct packed {
      logic [NCH-1:0]       sclk;
      logic [NCH-1:0]       sdo;
      logic [NCH-1:0]       oe;
      logic [BANK_NBIT-1:0] cur;
      logic                 busy;
      logic                 done;
      logic                 err;
      logic                 sdi;
   } exp_t;

   exp_t exp_q[$];

   int m_phase, m_cur, m_target, m_idle_run, m_park_left;
   bit m_err;
   bit [NCH-1:0] m_sclk, m_sdo, m_oe;
   bit m_hist[$];   // samples of the routed SDA, oldest first

   function automatic void model_reset();
      m_phase = PH_SETTLED; m_cur = 0; m_target = 0; m_idle_run = 0; m_park_left = 0;
      m_err = 0; m_sclk = '0; m_sdo = '0; m_oe = '1;
      m_hist.delete();
      for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(1'b0);
   endfunction

   function automatic void model_step(input int sel, input bit sclk, input bit sdo,
                                      input bit en, input bit [NCH-1:0] sda);
      int ph = m_phase;
      int idle_new;
      m_sclk = '0; m_sdo = '0; m_oe = '1;
      if (ph == PH_SETTLED || ph == PH_WAIT_IDLE) begin
         m_sclk[m_cur] = sclk;
         m_sdo[m_cur]  = sdo & en;
         m_oe[m_cur]   = en;
      end
      m_err = (ph == PH_SETTLED) && (sel >= NCH);
      if (ph == PH_RETARGET) begin
         foreach (m_hist[i]) m_hist[i] = 1'b0;
      end else begin
         m_hist.push_back(sda[m_cur]);
         void'(m_hist.pop_front());
      end
      idle_new = (!sclk && !en) ? ((m_idle_run + 1 > IDLE_CYC) ? IDLE_CYC : m_idle_run + 1) : 0;
      case (ph)
         PH_SETTLED: if (sel < NCH && sel != m_cur) begin
            m_target = sel; m_phase = PH_WAIT_IDLE; idle_new = 0;
         end
         PH_WAIT_IDLE: begin
            if (sel == m_cur) m_phase = PH_SETTLED;
            else begin
               if (sel < NCH) m_target = sel;
               if (m_idle_run >= IDLE_CYC) begin
                  m_phase = PH_PARKED; m_park_left = GUARD_CYC;
               end
            end
         end
         PH_PARKED: begin
            m_park_left--;
            if (m_park_left == 0) m_phase = PH_RETARGET;
         end
         default: begin
            m_cur = m_target; m_phase = PH_SETTLED;
         end
      endcase
      m_idle_run = idle_new;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.sclk = m_sclk; e.sdo = m_sdo; e.oe = m_oe;
      e.cur  = BANK_NBIT'(m_cur);
      e.busy = (m_phase != PH_SETTLED);
      e.done = (m_phase == PH_RETARGET);
      e.err  = m_err;
      e.sdi  = (m_phase == PH_SETTLED && !m_oe[m_cur]) ? m_hist[0] : 1'b0;
      return e;
   endfunction

   // ---------------- driver helpers ----------------
   task automatic cycle(input int sel, input bit sclk, input bit sdo, input bit en,
                        input bit [NCH-1:0] sda, input bit rst);
      sel_bank  = BANK_NBIT'(sel);
      sclk_in   = sclk;
      sdo_in    = sdo;
      sdo_en_in = en;
      sda_i     = sda;
      rst_n     = !rst;
      if (rst) model_reset();
      else     model_step(sel, sclk, sdo, en, sda);
      exp_q.push_back(model_out());
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic switch_to(input int b);
      int n = 0;
      cycle(b, 0, 0, 0, '0, 0);
      while (!switch_done && n < 40) begin
         cycle(b, 0, 0, 0, '0, 0);
         n++;
      end
      check("switch_to_done", switch_done, 1);
      cycle(b, 0, 0, 0, '0, 0);
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_sclk_pad", sclk_pad, e.sclk);
            check("sb_sda_o", sda_o, e.sdo);
            check("sb_sda_oe", sda_oe, e.oe);
            check("sb_cur_bank", cur_bank, e.cur);
            check("sb_busy", busy, e.busy);
            check("sb_switch_done", switch_done, e.done);
            check("sb_err_bank", err_bank, e.err);
            check("sb_sdi_out", sdi_out, e.sdi);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int n, sel, len, mode;
      model_reset();
      @(negedge clk);
      repeat (3) cycle(0, 0, 0, 0, '0, 1);

      // switch latency from an idle bus
      repeat (12) cycle(0, 0, 0, 0, '0, 0);
      cycle(3, 0, 0, 0, '0, 0);
      check("t3_busy_next", busy, 1);
      n = 0;
      while (!switch_done && n < 40) begin
         cycle(3, 0, 0, 0, '0, 0);
         n++;
      end
      check("t3_latency", n, 13);
      cycle(3, 0, 0, 0, '0, 0);
      check("t3_cur_bank", cur_bank, 3);
      check("t3_busy_clear", busy, 0);

      // out-of-range request and abort during drain
      cycle(5, 0, 0, 0, '0, 0);
      check("t5_err_pulse", err_bank, 1);
      check("t5_cur_kept", cur_bank, 3);
      cycle(3, 0, 0, 0, '0, 0);
      check("t5_err_clear", err_bank, 0);
      cycle(1, 1, 0, 1, '0, 0);
      check("t5_drain_busy", busy, 1);
      cycle(3, 0, 0, 1, '0, 0);
      check("t5_abort_busy", busy, 0);
      check("t5_abort_cur", cur_bank, 3);

      // drain with an active engine: toggle sclk for 20 cycles
      for (int i = 0; i < 20; i++) cycle(0, i[0], 1, 1, '0, 0);
      check("t4_still_draining", busy, 1);
      switch_to(0);
      check("t4_cur_bank", cur_bank, 0);

      // reset in the middle of a park
      cycle(2, 0, 0, 0, '0, 0);
      n = 0;
      while (m_phase != PH_PARKED && n < 40) begin
         cycle(2, 0, 0, 0, '0, 0);
         n++;
      end
      check("t1_reached_park", m_phase, PH_PARKED);
      cycle(2, 0, 0, 0, '0, 0);
      rst_n = 1'b0;
      #1;
      check("t1_cur_bank", cur_bank, 0);
      check("t1_sda_oe", sda_oe, 4'b1111);
      check("t1_sclk_pad", sclk_pad, 0);
      check("t1_busy", busy, 0);
      @(negedge clk);
      cycle(0, 0, 0, 0, '0, 1);
      cycle(0, 0, 0, 0, '0, 0);

      // routing on bank 2
      switch_to(2);
      cycle(2, 1, 1, 1, '0, 0);
      check("t2_sclk_pad", sclk_pad, 4'b0100);
      check("t2_sda_o", sda_o, 4'b0100);
      check("t2_sda_oe", sda_oe, 4'b1111);
      cycle(2, 0, 1, 1, '0, 0);
      check("t2_sclk_low", sclk_pad, 4'b0000);

      // readback on bank 1
      switch_to(1);
      repeat (3) cycle(1, 0, 0, 0, 4'b0010, 0);
      check("t6_sdi_high", sdi_out, 1);
      cycle(1, 0, 0, 1, 4'b0010, 0);
      check("t6_sdi_masked", sdi_out, 0);

      // random traffic
      sel = 1;
      n = 0;
      while (n < 1500) begin
         mode = $urandom_range(0, 2);
         len  = $urandom_range(1, 20);
         if ($urandom_range(0, 9) < 3) sel = $urandom_range(0, 7);
         for (int i = 0; i < len; i++) begin
            if (mode != 2) cycle(sel, 0, 0, 0, NCH'($urandom), 0);
            else cycle(sel, 1'($urandom), 1'($urandom), 1'($urandom), NCH'($urandom), 0);
            if (mode == 2 && $urandom_range(0, 15) == 0) sel = $urandom_range(0, 7);
         end
         n += len;
      end
      repeat (2) cycle(sel, 0, 0, 0, '0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
